// File: rtl/ram32x32_bist_if.sv
// Memory-side bus of the 32x32 RAM BIST: word address, byte write enables,
// write data and registered read data.
interface ram32x32_bist_if;
    logic        mem_EN;
    logic [3:0]  mem_WE;
    logic [4:0]  mem_A;
    logic [31:0] mem_Di;
    logic [31:0] mem_Do;

    modport master (output mem_EN, output mem_WE, output mem_A, output mem_Di, input mem_Do);
    modport slave  (input mem_EN, input mem_WE, input mem_A, input mem_Di, output mem_Do);
endinterface

// File: rtl/ram32x32_bist.sv
// March-style BIST for a 32x32 RAM with byte enables: W0, R0W1, R1W0, R0 and a
// byte-lane pass, one memory op per cycle, with first-failure capture.
module ram32x32_bist #(
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [31:0]            pattern,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [4:0]             fail_addr,
    output logic [31:0]            fail_data,
    output logic [31:0]            fail_expect,
    output logic [7:0]             err_count,
    ram32x32_bist_if.master        mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0W1, S_R1W0, S_R0, S_BYTE, S_DRAIN, S_DONE
    } state_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [4:0]  a;
        logic [31:0] di;
        logic        rd;
        logic [31:0] exp;
    } op_t;

    // Memory op (and read expectation) for a sequence position; sub selects the
    // first or second op of a two-op element.
    function automatic op_t op_decode(input state_t st, input logic sub,
                                      input logic [4:0] a, input logic [31:0] p);
        op_t op;
        op    = '0;
        op.en = 1'b1;
        op.a  = a;
        case (st)
            S_W0:   begin op.we = 4'hF; op.di = p; end
            S_R0W1: begin
                if (sub) begin op.we = 4'hF; op.di = ~p; end
                else     begin op.rd = 1'b1; op.exp = p; end
            end
            S_R1W0: begin
                if (sub) begin op.we = 4'hF; op.di = p; end
                else     begin op.rd = 1'b1; op.exp = ~p; end
            end
            S_R0:   begin op.rd = 1'b1; op.exp = p; end
            S_BYTE: begin
                if (sub) begin op.rd = 1'b1; op.exp = {p[31:24], ~p[23:16], p[15:8], ~p[7:0]}; end
                else     begin op.we = 4'h5; op.di = ~p; end
            end
            default: op = '0;
        endcase
        return op;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic        sub_q, sub_d;
    logic [31:0] pat_q, pat_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d, fail_exp_q, fail_exp_d;
    logic [7:0]  err_q, err_d;
    op_t         op_q, op_d;
    logic        cmp_vld_q, cmp_vld_d;
    logic [31:0] cmp_exp_q, cmp_exp_d;
    logic [4:0]  cmp_addr_q, cmp_addr_d;
    logic        mismatch_s, first_s, finish_s;

    assign mismatch_s = cmp_vld_q & (mem.mem_Do != cmp_exp_q);
    assign first_s    = mismatch_s & (err_q == 8'd0);
    assign finish_s   = (state_q == S_DRAIN) | (STOP_ON_FAIL & mismatch_s);

    // Next-state: sequencing, result capture and the registered op for next cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sub_d       = sub_q;
        pat_d       = pat_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = first_s ? cmp_addr_q : fail_addr_q;
        fail_data_d = first_s ? mem.mem_Do : fail_data_q;
        fail_exp_d  = first_s ? cmp_exp_q  : fail_exp_q;
        err_d       = (mismatch_s && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        // a read captured at this edge is compared against mem_Do at the next one
        cmp_vld_d   = op_q.rd;
        cmp_exp_d   = op_q.exp;
        cmp_addr_d  = op_q.a;

        if (finish_s) begin
            state_d   = S_DONE;
            addr_d    = 5'd0;
            sub_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (err_q == 8'd0) && !mismatch_s;
            cmp_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_W0;
                        addr_d      = 5'd0;
                        sub_d       = 1'b0;
                        pat_d       = pattern;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        pass_d      = 1'b0;
                        fail_addr_d = 5'd0;
                        fail_data_d = 32'd0;
                        fail_exp_d  = 32'd0;
                        err_d       = 8'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_W0: begin
                    if (addr_q == 5'd31) begin state_d = S_R0W1; addr_d = 5'd0; end
                    else                 begin addr_d = addr_q + 5'd1; end
                end
                S_R0W1: begin
                    sub_d = ~sub_q;
                    if (sub_q && (addr_q == 5'd31)) begin state_d = S_R1W0; addr_d = 5'd31; end
                    else                            begin addr_d = sub_q ? addr_q + 5'd1 : addr_q; end
                end
                S_R1W0: begin
                    sub_d = ~sub_q;
                    if (sub_q && (addr_q == 5'd0)) begin state_d = S_R0; addr_d = 5'd0; end
                    else                           begin addr_d = sub_q ? addr_q - 5'd1 : addr_q; end
                end
                S_R0: begin
                    if (addr_q == 5'd31) begin state_d = S_BYTE; addr_d = 5'd0; end
                    else                 begin addr_d = addr_q + 5'd1; end
                end
                S_BYTE: begin
                    sub_d = ~sub_q;
                    if (sub_q && (addr_q == 5'd31)) begin state_d = S_DRAIN; addr_d = 5'd0; end
                    else                            begin addr_d = sub_q ? addr_q + 5'd1 : addr_q; end
                end
                S_DRAIN: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        op_d = op_decode(state_d, sub_d, addr_d, pat_d);
    end

    // State and output registers; RST wins over start and drops any pending compare.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= 5'd0;
            sub_q       <= 1'b0;
            pat_q       <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= 5'd0;
            fail_data_q <= 32'd0;
            fail_exp_q  <= 32'd0;
            err_q       <= 8'd0;
            op_q        <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 32'd0;
            cmp_addr_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sub_q       <= sub_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
            err_q       <= err_d;
            op_q        <= op_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign fail_expect = fail_exp_q;
    assign err_count   = err_q;
    assign mem.mem_EN  = op_q.en;
    assign mem.mem_WE  = op_q.we;
    assign mem.mem_A   = op_q.a;
    assign mem.mem_Di  = op_q.di;

endmodule

// File: tb/tb_ram32x32_bist.sv
// Bench for ram32x32_bist: a halting and a counting instance run side by side,
// each on its own behavioural RAM with shared fault injection.
module tb_ram32x32_bist;

    typedef struct {
        logic        pass;
        logic [7:0]  err;
        logic [4:0]  faddr;
        logic [31:0] fdata;
        logic [31:0] fexp;
        int          done_edge;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        CLK, RST, start;
    logic [31:0] pattern;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [4:0]  faddr_a, faddr_b;
    logic [31:0] fdata_a, fdata_b, fexp_a, fexp_b;
    logic [7:0]  err_a, err_b;

    ram32x32_bist_if ifa ();
    ram32x32_bist_if ifb ();

    ram32x32_bist #(.STOP_ON_FAIL(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .pattern(pattern),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_addr(faddr_a),
        .fail_data(fdata_a), .fail_expect(fexp_a), .err_count(err_a), .mem(ifa.master)
    );

    ram32x32_bist #(.STOP_ON_FAIL(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .pattern(pattern),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_addr(faddr_b),
        .fail_data(fdata_b), .fail_expect(fexp_b), .err_count(err_b), .mem(ifb.master)
    );

    // Fault injection: per-word stuck-at-1 mask on reads, and lane 1 written by WE[0].
    logic [31:0] stuck [32];
    logic        lane_bug;
    logic [31:0] ram_a [32];
    logic [31:0] ram_b [32];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                          input logic [3:0] we, input logic bug);
        logic [31:0] r;
        logic        en1;
        r   = old;
        en1 = bug ? we[0] : we[1];
        if (we[0]) r[7:0]   = di[7:0];
        if (en1)   r[15:8]  = di[15:8];
        if (we[2]) r[23:16] = di[23:16];
        if (we[3]) r[31:24] = di[31:24];
        return r;
    endfunction

    always @(posedge CLK) begin
        if (ifa.mem_EN) begin
            if (ifa.mem_WE == 4'h0) ifa.mem_Do <= ram_a[ifa.mem_A] | stuck[ifa.mem_A];
            else ram_a[ifa.mem_A] <= merge(ram_a[ifa.mem_A], ifa.mem_Di, ifa.mem_WE, lane_bug);
        end
    end

    always @(posedge CLK) begin
        if (ifb.mem_EN) begin
            if (ifb.mem_WE == 4'h0) ifb.mem_Do <= ram_b[ifb.mem_A] | stuck[ifb.mem_A];
            else ram_b[ifb.mem_A] <= merge(ram_b[ifb.mem_A], ifb.mem_Di, ifb.mem_WE, lane_bug);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Observed outputs indexed by instance: 0 = halting, 1 = counting.
    logic        ob_busy [2], ob_done [2], ob_pass [2], ob_en [2];
    logic [3:0]  ob_we [2];
    logic [4:0]  ob_a [2], ob_faddr [2];
    logic [31:0] ob_di [2], ob_fdata [2], ob_fexp [2];
    logic [7:0]  ob_err [2];
    assign ob_busy[0] = busy_a;  assign ob_busy[1] = busy_b;
    assign ob_done[0] = done_a;  assign ob_done[1] = done_b;
    assign ob_pass[0] = pass_a;  assign ob_pass[1] = pass_b;
    assign ob_en[0] = ifa.mem_EN; assign ob_en[1] = ifb.mem_EN;
    assign ob_we[0] = ifa.mem_WE; assign ob_we[1] = ifb.mem_WE;
    assign ob_a[0]  = ifa.mem_A;  assign ob_a[1]  = ifb.mem_A;
    assign ob_di[0] = ifa.mem_Di; assign ob_di[1] = ifb.mem_Di;
    assign ob_faddr[0] = faddr_a; assign ob_faddr[1] = faddr_b;
    assign ob_fdata[0] = fdata_a; assign ob_fdata[1] = fdata_b;
    assign ob_fexp[0]  = fexp_a;  assign ob_fexp[1]  = fexp_b;
    assign ob_err[0]   = err_a;   assign ob_err[1]   = err_b;

    exp_t        qa[$], qb[$];
    logic [31:0] cur_pat;
    logic        end_req;
    int          n_chk = 0, n_err = 0;
    logic        busy_prev [2], done_prev [2], wd [2];
    int          acc_cyc [2], nrd [2], nwr [2];

    // Expected bus op k (1..256) after the accept edge: {EN, WE, A, Di}.
    function automatic logic [41:0] exp_op(input int k, input logic [31:0] p);
        int          j;
        logic [4:0]  a;
        logic [41:0] r;
        r = 42'd0;
        if (k >= 1 && k <= 32) begin
            r = {1'b1, 4'hF, 5'(k - 1), p};
        end else if (k >= 33 && k <= 96) begin
            j = k - 33; a = 5'(j / 2);
            r = (j % 2 == 0) ? {1'b1, 4'h0, a, 32'h0} : {1'b1, 4'hF, a, ~p};
        end else if (k >= 97 && k <= 160) begin
            j = k - 97; a = 5'(31 - j / 2);
            r = (j % 2 == 0) ? {1'b1, 4'h0, a, 32'h0} : {1'b1, 4'hF, a, p};
        end else if (k >= 161 && k <= 192) begin
            r = {1'b1, 4'h0, 5'(k - 161), 32'h0};
        end else if (k >= 193 && k <= 256) begin
            j = k - 193; a = 5'(j / 2);
            r = (j % 2 == 0) ? {1'b1, 4'h5, a, ~p} : {1'b1, 4'h0, a, 32'h0};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, want 0x%0h", tag, name, act, req);
        end
    endtask

    task automatic mon_dut(input int d);
        exp_t        e;
        logic [41:0] eo, ao;
        int          k;
        string       tag;
        tag = (d == 0) ? "stop" : "run";
        if (RST) begin
            chk(tag, "rst_busy", 64'(ob_busy[d]), 64'd0);
            chk(tag, "rst_done", 64'(ob_done[d]), 64'd0);
            chk(tag, "rst_pass", 64'(ob_pass[d]), 64'd0);
            chk(tag, "rst_bus", {22'd0, ob_en[d], ob_we[d], ob_a[d], ob_di[d]}, 64'd0);
            chk(tag, "rst_fail", {27'd0, ob_faddr[d], ob_fdata[d]} | 64'(ob_fexp[d]), 64'd0);
            chk(tag, "rst_err", 64'(ob_err[d]), 64'd0);
            busy_prev[d] = 1'b0;
            done_prev[d] = 1'b0;
            return;
        end
        if (ob_busy[d] && !busy_prev[d]) begin
            acc_cyc[d] = cyc; nrd[d] = 0; nwr[d] = 0; wd[d] = 1'b0;
            chk(tag, "start_clr_done", 64'(ob_done[d]), 64'd0);
            chk(tag, "start_clr_pass", 64'(ob_pass[d]), 64'd0);
            chk(tag, "start_clr_err", 64'(ob_err[d]), 64'd0);
            chk(tag, "start_clr_fail", {27'd0, ob_faddr[d], ob_fdata[d]} | 64'(ob_fexp[d]), 64'd0);
        end
        if (ob_busy[d]) begin
            k  = cyc - acc_cyc[d] + 1;
            eo = exp_op(k, cur_pat);
            ao = {ob_en[d], ob_we[d], eo[41] ? ob_a[d] : 5'd0, ob_di[d]};
            chk(tag, $sformatf("op%0d", k), 64'(ao), 64'(eo));
            if (ob_en[d]) begin
                if (ob_we[d] != 4'h0) nwr[d]++;
                else                  nrd[d]++;
            end
            if ((k > 300) && !wd[d]) begin
                wd[d] = 1'b1; n_chk++; n_err++;
                $display("FAIL %s.busy_bound: busy for %0d cycles, want at most 257", tag, k);
            end
        end
        if (ob_done[d] && !done_prev[d]) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
                n_chk++; n_err++;
                $display("FAIL %s.unexpected_done: done rose with no run pending", tag);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk(tag, "pass", 64'(ob_pass[d]), 64'(e.pass));
                chk(tag, "err_count", 64'(ob_err[d]), 64'(e.err));
                chk(tag, "fail_addr", 64'(ob_faddr[d]), 64'(e.faddr));
                chk(tag, "fail_data", 64'(ob_fdata[d]), 64'(e.fdata));
                chk(tag, "fail_expect", 64'(ob_fexp[d]), 64'(e.fexp));
                chk(tag, "done_edge", 64'(cyc - acc_cyc[d]), 64'(e.done_edge));
                chk(tag, "n_reads", 64'(nrd[d]), 64'(e.nrd));
                chk(tag, "n_writes", 64'(nwr[d]), 64'(e.nwr));
                chk(tag, "en_after_done", 64'(ob_en[d]), 64'd0);
                chk(tag, "busy_after_done", 64'(ob_busy[d]), 64'd0);
            end
        end
        busy_prev[d] = ob_busy[d];
        done_prev[d] = ob_done[d];
    endtask

    // Monitor/scoreboard: samples on the falling edge, pops on each done rise.
    initial begin
        busy_prev[0] = 1'b0; busy_prev[1] = 1'b0;
        done_prev[0] = 1'b0; done_prev[1] = 1'b0;
        wd[0] = 1'b0; wd[1] = 1'b0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        nrd[0] = 0; nrd[1] = 0; nwr[0] = 0; nwr[1] = 0;
        forever begin
            @(negedge CLK);
            mon_dut(0);
            mon_dut(1);
            if (end_req) begin
                chk("stop", "pending_runs", 64'(qa.size()), 64'd0);
                chk("run", "pending_runs", 64'(qb.size()), 64'd0);
                $display("Result: errors=%0d of %0d checks", n_err, n_chk);
                $finish;
            end
        end
    end

    function automatic exp_t mk(input logic p, input logic [7:0] err, input logic [4:0] fa,
                                input logic [31:0] fd, input logic [31:0] fe,
                                input int de, input int nr, input int nw);
        exp_t e;
        e.pass = p; e.err = err; e.faddr = fa; e.fdata = fd; e.fexp = fe;
        e.done_edge = de; e.nrd = nr; e.nwr = nw;
        return e;
    endfunction

    task automatic do_start(input logic [31:0] p);
        @(negedge CLK); #1;
        cur_pat = p; pattern = p; start = 1'b1;
        @(negedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic run(input logic [31:0] p, input exp_t ea, input exp_t eb);
        qa.push_back(ea);
        qb.push_back(eb);
        do_start(p);
        wait_idle();
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; pattern = 32'd0; cur_pat = 32'd0;
        lane_bug = 1'b0; end_req = 1'b0;
        for (int i = 0; i < 32; i++) stuck[i] = 32'd0;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;

        // clean RAM, full run on both instances
        run(32'hA5A55A5A, mk(1'b1, 8'd0, 5'd0, 32'd0, 32'd0, 257, 128, 128),
                          mk(1'b1, 8'd0, 5'd0, 32'd0, 32'd0, 257, 128, 128));

        // word 17 bit 3 stuck-at-1: halt at R0W1 read of 17 (op 67, detected edge 68)
        stuck[17] = 32'h0000_0008;
        run(32'h0, mk(1'b0, 8'd1, 5'd17, 32'h8, 32'h0, 68, 18, 50),
                   mk(1'b0, 8'd2, 5'd17, 32'h8, 32'h0, 257, 128, 128));
        stuck[17] = 32'd0;

        // lane 1 follows WE[0]: every BYTE read sees lane 1 flipped
        lane_bug = 1'b1;
        run(32'h0, mk(1'b0, 8'd1, 5'd0, 32'h00FFFFFF, 32'h00FF00FF, 195, 97, 98),
                   mk(1'b0, 8'd32, 5'd0, 32'h00FFFFFF, 32'h00FF00FF, 257, 128, 128));
        lane_bug = 1'b0;

        // words 5 and 17 stuck: R0W1 and R0 each fail twice
        stuck[5] = 32'h0000_0008; stuck[17] = 32'h0000_0008;
        run(32'h0, mk(1'b0, 8'd1, 5'd5, 32'h8, 32'h0, 44, 6, 38),
                   mk(1'b0, 8'd4, 5'd5, 32'h8, 32'h0, 257, 128, 128));
        stuck[5] = 32'd0; stuck[17] = 32'd0;

        // reset around cycle 100 of a run, then a clean run with a start ignored mid-run
        do_start(32'h0F0F0F0F);
        repeat (98) @(negedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK); #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        qa.push_back(mk(1'b1, 8'd0, 5'd0, 32'd0, 32'd0, 257, 128, 128));
        qb.push_back(mk(1'b1, 8'd0, 5'd0, 32'd0, 32'd0, 257, 128, 128));
        do_start(32'h12345678);
        repeat (60) @(negedge CLK);
        #1 pattern = 32'hFFFFFFFF; start = 1'b1;
        @(negedge CLK); #1 start = 1'b0;
        wait_idle();

        end_req = 1'b1;
        repeat (5) @(negedge CLK);
    end

endmodule
